program_loader: RTL
===================

Name: program_loader

Overview:
- Upstream of the multicycle CPU core.
- Receives a program as a byte stream (valid/ready) and packs each 20-bit instruction into the core's 64-bit memory word format.
- Writes the packed words into RAM at consecutive instruction addresses.
- Holds the core in reset until the whole program has been loaded.

Parameters:
- ADDRESS_SIZE, 11, RAM address width (matches core PC width).
- WORD_SIZE, 64, RAM data word width.
- INSTRUCTION_SIZE, 20, instruction width.
- ADDR_STRIDE, 4, address increment per instruction (matches PC+4).
- MAX_INSTRUCTIONS, 512, capacity; loading more is an error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load from address 0.
- inValid  input  1  inByte is valid.
- inByte  input  8  program byte, big-endian, 3 bytes per instruction.
- inLast  input  1  qualifies the final byte of the program.
- inReady  output  1  loader accepts a byte this cycle.
- memAddress  output  ADDRESS_SIZE  RAM write address.
- memData  output  WORD_SIZE  RAM write data.
- memWrite  output  1  RAM write strobe.
- cpuReset  output  1  drives the core's reset.
- busy  output  1  load in progress.
- done  output  1  load completed successfully.
- error  output  1  load aborted.
- count  output  10  instructions written in the current load.

Behaviour:
- All outputs are registered except inReady, which is decoded from state.
- Reset values:
  - state IDLE.
  - memAddress 0, memData 0, memWrite 0.
  - cpuReset 1.
  - busy 0, done 0, error 0, count 0.
  - byte index 0, inReady 0.
- Reset asserted mid-load: the same values apply immediately; the partial program is abandoned and no further writes occur.
- States: IDLE, RECV, WRITE, DONE, ERROR.
  - IDLE: cpuReset=1. start -> RECV; write address := 0, count := 0.
  - RECV: inReady=1, busy=1. A byte is accepted on inValid && inReady.
    - Byte 0 fills instr[19:16] from inByte[3:0]. If inByte[7:4] != 0 -> ERROR.
    - Byte 1 fills instr[15:8].
    - Byte 2 fills instr[7:0]; byte index returns to 0; go to WRITE and register memData and memAddress.
    - inLast on byte 0 or byte 1 -> ERROR (partial instruction).
    - inLast on byte 2 is recorded and applied after the write.
  - WRITE: lasts one cycle.
    - memWrite=1 and inReady=0.
    - memData = {12'b0, instr[19:0], 32'b0}: instruction at bits [51:32], matching the core's 32-bit-aligned, zero-padded fetch.
    - At the end of the cycle: count += 1; write address += ADDR_STRIDE, wrapping modulo 2^ADDRESS_SIZE.
    - Next state: DONE if inLast was recorded; else ERROR if count+1 == MAX_INSTRUCTIONS; else RECV.
  - DONE: cpuReset=0, done=1, busy=0. count is held. start -> RECV; cpuReset returns to 1 on the next cycle and done clears.
  - ERROR: cpuReset=1, error=1, busy=0. start -> RECV and clears error.
- start is ignored in RECV and WRITE.
- inValid without inReady is ignored; the byte is not consumed.
- Latency: a write occurs on the cycle after the third byte is accepted.
- Maximum acceptance rate is 3 bytes per 4 cycles.
- memWrite is never asserted outside WRITE.
- memAddress and memData hold their last values when memWrite=0.
- Exactly MAX_INSTRUCTIONS instructions with inLast on the last byte -> DONE, not ERROR.
- The overflow check takes priority only when inLast is absent.

Test Plan:
- Reset, then start; send bytes 0x0A,0xBC,0xDE with inLast on 0xDE.
  - One write: memAddress=0, memData=0x000ABCDE00000000.
  - Then DONE: cpuReset=0, done=1, count=1.
- Three instructions streamed with inValid held high.
  - Writes at addresses 0, 4 and 8.
  - inReady low for exactly one cycle after every third byte.
  - count=3 at DONE.
- inLast asserted on the second byte of an instruction.
  - ERROR: error=1, cpuReset=1, no memWrite.
  - A subsequent start clears error and enters RECV.
- First byte 0x1F.
  - ERROR immediately; no write occurs.
- 512 instructions with no inLast.
  - The 512th write occurs, then ERROR.
  - With inLast on the final byte instead, the result is DONE with count=512.
- reset asserted during byte 1 of the second instruction.
  - All outputs return to their reset values at once.
  - After a fresh start, the first write goes to address 0.

Source files
------------

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Receives a program as a valid/ready byte stream (3 bytes per
//               20-bit instruction, big-endian), packs each instruction into
//               the core's 64-bit memory word (instruction at [51:32]) and
//               writes it to consecutive RAM addresses. The CPU core is held
//               in reset until a load completes successfully.
// Ports       : clk, reset (async, active high)
//               start                      - begin a new load at address 0
//               inValid/inByte/inLast      - byte stream in
//               inReady                    - byte accepted this cycle
//               memAddress/memData/memWrite- RAM write port
//               cpuReset                   - reset to the core
//               busy/done/error            - load status
//               count                      - instructions written this load
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int ADDRESS_SIZE     = 11,
    parameter int WORD_SIZE        = 64,
    parameter int INSTRUCTION_SIZE = 20,
    parameter int ADDR_STRIDE      = 4,
    parameter int MAX_INSTRUCTIONS = 512
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    inValid,
    input  logic [7:0]              inByte,
    input  logic                    inLast,
    output logic                    inReady,
    output logic [ADDRESS_SIZE-1:0] memAddress,
    output logic [WORD_SIZE-1:0]    memData,
    output logic                    memWrite,
    output logic                    cpuReset,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [9:0]              count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [1:0]              r_byteIdx;
    logic [11:0]             r_instrHi;    // instr[19:8], buffered until byte 2 arrives
    logic [ADDRESS_SIZE-1:0] r_writeAddr;
    logic                    r_lastSeen;
    logic                    w_accept;
    logic                    w_startLoad;
    logic                    w_full;
    logic [WORD_SIZE-1:0]    w_packed;

    assign inReady     = (r_state == ST_RECV);
    assign w_accept    = inValid && inReady;
    assign w_startLoad = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERROR));
    // The write in progress is the last one that fits.
    assign w_full      = ((32'(count) + 32'd1) == MAX_INSTRUCTIONS);

    // Byte 2 bypasses the buffer so the word can be registered on acceptance.
    always_comb begin
        w_packed = '0;
        w_packed[32 +: INSTRUCTION_SIZE] = {r_instrHi, inByte};
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) w_nextState = ST_RECV;
            end
            ST_RECV: begin
                if (w_accept) begin
                    case (r_byteIdx)
                        2'd0: begin
                            if ((inByte[7:4] != 4'd0) || inLast) w_nextState = ST_ERROR;
                        end
                        2'd1: begin
                            if (inLast) w_nextState = ST_ERROR;
                        end
                        default: w_nextState = ST_WRITE;
                    endcase
                end
            end
            ST_WRITE: begin
                // A terminated program wins over the capacity check.
                if (r_lastSeen)  w_nextState = ST_DONE;
                else if (w_full) w_nextState = ST_ERROR;
                else             w_nextState = ST_RECV;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_byteIdx   <= 2'd0;
            r_instrHi   <= 12'd0;
            r_writeAddr <= '0;
            r_lastSeen  <= 1'b0;
            memAddress  <= '0;
            memData     <= '0;
            memWrite    <= 1'b0;
            cpuReset    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            count       <= 10'd0;
        end else begin
            r_state  <= w_nextState;
            // Status outputs are registered from the next state so they
            // always line up with the state they describe.
            memWrite <= (w_nextState == ST_WRITE);
            busy     <= (w_nextState == ST_RECV) || (w_nextState == ST_WRITE);
            done     <= (w_nextState == ST_DONE);
            error    <= (w_nextState == ST_ERROR);
            cpuReset <= (w_nextState != ST_DONE);

            if (w_startLoad) begin
                r_writeAddr <= '0;
                count       <= 10'd0;
                r_byteIdx   <= 2'd0;
                r_lastSeen  <= 1'b0;
            end

            if (w_accept) begin
                case (r_byteIdx)
                    2'd0: begin
                        r_instrHi[11:8] <= inByte[3:0];
                        r_byteIdx       <= 2'd1;
                    end
                    2'd1: begin
                        r_instrHi[7:0] <= inByte;
                        r_byteIdx      <= 2'd2;
                    end
                    default: begin
                        memAddress <= r_writeAddr;
                        memData    <= w_packed;
                        r_lastSeen <= inLast;
                        r_byteIdx  <= 2'd0;
                    end
                endcase
            end

            if (r_state == ST_WRITE) begin
                count       <= count + 10'd1;
                r_writeAddr <= r_writeAddr + ADDRESS_SIZE'(ADDR_STRIDE);
            end
        end
    end

endmodule
`default_nettype wire
